// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the supported operand-width range.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor (x - y - bin) built from two half-subtractor
// stages whose borrows are merged by an OR gate.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hd1_s;
  logic hb1_s;
  logic hb2_s;

  // first half stage: x - y
  assign hd1_s = x ^ y;
  assign hb1_s = ~x & y;

  // second half stage: (x - y) - bin
  assign d     = hd1_s ^ bin;
  assign hb2_s = ~hd1_s & bin;

  assign bout  = hb1_s | hb2_s;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_subtractor: WIDTH out of supported range");
    end
  endgenerate

  state_e           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             fs_d_s;
  logic             fs_bo_s;

  full_subtractor u_fs (
    .x    (sa_r[0]),
    .y    (sb_r[0]),
    .bin  (br_r),
    .d    (fs_d_s),
    .bout (fs_bo_s)
  );

  // FSM, operand shifters, bit counter, borrow FF and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      sa_r      <= '0;
      sb_r      <= '0;
      res_r     <= '0;
      cnt_r     <= '0;
      br_r      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sa_r     <= a;
            sb_r     <= b;
            res_r    <= '0;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa_r  <= sa_r >> 1;
          sb_r  <= sb_r >> 1;
          res_r <= {fs_d_s, res_r[WIDTH-1:1]};
          br_r  <= fs_bo_s;
          cnt_r <= cnt_r + CW'(1);
          // last bit: publish the assembled result together with the final borrow
          if (cnt_r == CNT_LAST) begin
            diff      <= {fs_d_s, res_r[WIDTH-1:1]};
            borrow    <= fs_bo_s;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench: WIDTH=8 table of operations and corner-case
// sequences, plus an exhaustive WIDTH=2 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, rst_n2;
  logic       in_valid, in_ready, out_valid, out_ready, borrow;
  logic [7:0] a, b, diff;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow2;
  logic [1:0] a2, b2, diff2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .borrow(borrow2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait after the accepting edge for out_valid of the 8-bit instance
  task automatic wait_out8(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out8(lat);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow, eb);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ret_in_ready"}, in_ready, 1);
    check({tag, "_ret_out_valid"}, out_valid, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 8'h01, 1'b0};
    vecs[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0};
    vecs[6] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    rst_n = 1'b0; rst_n2 = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = 2'b00; b2 = 2'b00;
    tick(); tick();
    rst_n = 1'b1; rst_n2 = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    tick();

    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, $sformatf("vec%0d", i));

    // backpressure: result held for 5 cycles with out_ready low
    a = 8'h80; b = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out8(lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, 8'h7F);
      check("bp_borrow", borrow, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // in_valid held through RUN and DONE with changed operands
    a = 8'h33; b = 8'h11; in_valid = 1'b1;
    tick();
    a = 8'hAA; b = 8'h55;
    wait_out8(lat);
    check("hold_latency", lat, 8);
    check("hold_diff", diff, 8'h22);
    check("hold_borrow", borrow, 0);
    tick();
    check("hold_done_in_ready", in_ready, 0);
    check("hold_done_diff", diff, 8'h22);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_idle_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("hold_accept2", in_ready, 0);
    wait_out8(lat);
    check("hold2_latency", lat, 8);
    check("hold2_diff", diff, 8'h55);
    check("hold2_borrow", borrow, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset on the 4th RUN edge aborts the operation
    a = 8'h5A; b = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_result", out_valid, 0);
    end
    op8(8'h10, 8'h20, 8'hF0, 1'b1, "post_abort");

    // WIDTH=2: all 16 operand pairs back-to-back
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [1:0] ai, bj, ed;
        ai = 2'(i); bj = 2'(j);
        ed = ai - bj;
        check("w2_in_ready", in_ready2, 1);
        a2 = ai; b2 = bj; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
          tick();
          lat++;
          if (out_valid2) break;
        end
        check($sformatf("w2_lat_%0d_%0d", i, j), lat, 2);
        check($sformatf("w2_diff_%0d_%0d", i, j), diff2, ed);
        check($sformatf("w2_borrow_%0d_%0d", i, j), borrow2, (i < j) ? 1 : 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
